// File: rtl/bcd_pkg.sv
// ============================================================================
// bcd_pkg : shared constants, FSM encoding and add-3 helper for the BCD
//           sequential converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] digit);
        return (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// bcd_digit_adj : combinational 4-bit double-dabble add-3 corrector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    assign o_digit = add3(i_digit);

endmodule

`default_nettype wire

// File: rtl/bcd_seq_converter.sv
// ============================================================================
// bcd_seq_converter : iterative double-dabble binary-to-BCD converter, one
//                     shift per clock, valid/ready on both sides.
//                     Optional digit_blank output enabled by BCD_BLANK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIN_W-1:0]          in_bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGITS*DIGIT_W-1:0] bcd_out,
    output logic                      ovf
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]         digit_blank
`endif
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int BCD_W = DIGITS * DIGIT_W;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   digits_q, digits_d, digits_adj;
    logic               ovf_q, ovf_d;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (digits_q[i*DIGIT_W +: DIGIT_W]),
            .o_digit (digits_adj[i*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d    = in_bin;
                    digits_d = '0;
                    ovf_d    = 1'b0;
                    cnt_d    = CNT_W'(BIN_W - 1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // The MSB of the corrected top digit is lost by the shift; keep it as overflow.
                {digits_d, bin_d} = {digits_adj[BCD_W-2:0], bin_q, 1'b0};
                ovf_d = ovf_q | digits_adj[BCD_W-1];
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bin_q    <= '0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd_out   = digits_q;
    assign ovf       = ovf_q;

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;

    for (genvar i = 0; i < DIGITS; i++) begin : g_blank
        if (i == 0) begin : g_ones
            assign blank_d[i] = 1'b0;
        end else begin : g_upper
            assign blank_d[i] = (digits_d[BCD_W-1:i*DIGIT_W] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign digit_blank = blank_q;
`endif

endmodule

`default_nettype wire
